// File: rtl/wb_stream_rd_ctrl.sv
// Wishbone burst reader that streams a circular memory buffer into a downstream FIFO.
// Optional bus-error termination is enabled with `define WB_STREAM_RD_ERR_EN.
module wb_stream_rd_ctrl #(
  parameter int unsigned WB_AW         = 32,
  parameter int unsigned WB_DW         = 32,
  parameter int unsigned FIFO_AW       = 4,
  parameter int unsigned MAX_BURST_LEN = 16
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  output logic [WB_AW-1:0]     wbm_adr_o,
  output logic [WB_DW-1:0]     wbm_dat_o,
  output logic [WB_DW/8-1:0]   wbm_sel_o,
  output logic                 wbm_we_o,
  output logic                 wbm_cyc_o,
  output logic                 wbm_stb_o,
  output logic [2:0]           wbm_cti_o,
  output logic [1:0]           wbm_bte_o,
  input  logic [WB_DW-1:0]     wbm_dat_i,
  input  logic                 wbm_ack_i,
  input  logic                 wbm_err_i,
  input  logic                 wbm_rty_i,
  output logic [WB_DW-1:0]     fifo_d,
  output logic                 fifo_wr,
  input  logic [FIFO_AW:0]     fifo_cnt,
  input  logic                 enable,
  input  logic [WB_AW-1:0]     start_adr,
  input  logic [WB_AW-1:0]     buf_size,
  input  logic [WB_AW-1:0]     burst_size,
  input  logic                 continous,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int unsigned BYTES = WB_DW / 8;
  localparam int unsigned BCW   = $clog2(MAX_BURST_LEN + 1);

  localparam logic [2:0] CtiIdle   = 3'b000;
  localparam logic [2:0] CtiLinear = 3'b010;
  localparam logic [2:0] CtiLast   = 3'b111;

  if (FIFO_AW == 0) begin : g_fifo_aw_chk
    $error("wb_stream_rd_ctrl: FIFO_AW must be greater than 0");
  end

  typedef enum logic [1:0] {StIdle, StWait, StBurst} state_t;

  state_t             r_state, w_state_nxt;
  logic [WB_AW-1:0]   r_start, w_start_nxt;
  logic [WB_AW-1:0]   r_size, w_size_nxt;
  logic [WB_AW-1:0]   r_bsize, w_bsize_nxt;
  logic [WB_AW-1:0]   r_offset, w_offset_nxt;
  logic [BCW-1:0]     r_beat, w_beat_nxt;
  logic [BCW-1:0]     r_blen, w_blen_nxt;
  logic [WB_AW-1:0]   r_adr, w_adr_nxt;
  logic               r_cyc, w_cyc_nxt;
  logic [2:0]         r_cti, w_cti_nxt;
  logic [WB_DW-1:0]   r_fifo_d, w_fifo_d_nxt;
  logic               r_fifo_wr, w_fifo_wr_nxt;
  logic               r_done, w_done_nxt;
  logic               r_err, w_err_nxt;

  logic [WB_AW-1:0]   w_remain, w_bsz, w_bclamp, w_blen_full, w_depth, w_space;
  logic [BCW-1:0]     w_blen;
  logic               w_fifo_ok, w_ack, w_last, w_buf_end;

  // Effective burst length: never zero, never over the cap, never past the buffer end.
  always_comb begin
    w_remain    = r_size - r_offset;
    w_bsz       = (r_bsize == '0) ? WB_AW'(1) : r_bsize;
    w_bclamp    = (w_bsz > WB_AW'(MAX_BURST_LEN)) ? WB_AW'(MAX_BURST_LEN) : w_bsz;
    w_blen_full = (w_remain < w_bclamp) ? w_remain : w_bclamp;
    w_blen      = BCW'(w_blen_full);
    w_depth     = WB_AW'(1) << FIFO_AW;
    w_space     = w_depth - WB_AW'(fifo_cnt);
    w_fifo_ok   = (w_space >= w_blen_full);
  end

  // Retry and (when not enabled as a fault) error both count as "no acknowledge".
  assign w_ack     = r_cyc & wbm_ack_i & ~wbm_rty_i & ~wbm_err_i;
  assign w_last    = (r_beat == r_blen - BCW'(1));
  assign w_buf_end = ((r_offset + WB_AW'(1)) == r_size);

  always_comb begin
    w_state_nxt   = r_state;
    w_start_nxt   = r_start;
    w_size_nxt    = r_size;
    w_bsize_nxt   = r_bsize;
    w_offset_nxt  = r_offset;
    w_beat_nxt    = r_beat;
    w_blen_nxt    = r_blen;
    w_adr_nxt     = r_adr;
    w_cyc_nxt     = r_cyc;
    w_cti_nxt     = r_cti;
    w_fifo_d_nxt  = r_fifo_d;
    w_fifo_wr_nxt = 1'b0;
    w_done_nxt    = 1'b0;
    w_err_nxt     = r_err;

    unique case (r_state)
      StIdle: begin
        if (enable && (buf_size != '0) && !r_err) begin
          w_start_nxt  = start_adr;
          w_size_nxt   = buf_size;
          w_bsize_nxt  = burst_size;
          w_offset_nxt = '0;
          w_state_nxt  = StWait;
        end
      end

      StWait: begin
        if (!enable) begin
          w_state_nxt = StIdle;
        end else if (w_fifo_ok) begin
          w_cyc_nxt   = 1'b1;
          w_adr_nxt   = r_start + r_offset * WB_AW'(BYTES);
          w_beat_nxt  = '0;
          w_blen_nxt  = w_blen;
          w_cti_nxt   = (w_blen == BCW'(1)) ? CtiLast : CtiLinear;
          w_state_nxt = StBurst;
        end
      end

      StBurst: begin
`ifdef WB_STREAM_RD_ERR_EN
        if (r_cyc && wbm_err_i) begin
          w_cyc_nxt   = 1'b0;
          w_cti_nxt   = CtiIdle;
          w_err_nxt   = 1'b1;
          w_state_nxt = StIdle;
        end else
`endif
        if (w_ack) begin
          w_fifo_d_nxt  = wbm_dat_i;
          w_fifo_wr_nxt = 1'b1;
          w_offset_nxt  = r_offset + WB_AW'(1);
          w_adr_nxt     = r_adr + WB_AW'(BYTES);
          w_beat_nxt    = r_beat + BCW'(1);
          if (w_last) begin
            w_cyc_nxt = 1'b0;
            w_cti_nxt = CtiIdle;
            if (w_buf_end) begin
              w_done_nxt   = 1'b1;
              w_offset_nxt = '0;
              w_state_nxt  = (continous && enable) ? StWait : StIdle;
            end else begin
              w_state_nxt  = enable ? StWait : StIdle;
            end
          end else begin
            w_cti_nxt = ((r_beat + BCW'(2)) == r_blen) ? CtiLast : CtiLinear;
          end
        end
      end

      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state   <= StIdle;
      r_start   <= '0;
      r_size    <= '0;
      r_bsize   <= '0;
      r_offset  <= '0;
      r_beat    <= '0;
      r_blen    <= '0;
      r_adr     <= '0;
      r_cyc     <= 1'b0;
      r_cti     <= CtiIdle;
      r_fifo_d  <= '0;
      r_fifo_wr <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_start   <= w_start_nxt;
      r_size    <= w_size_nxt;
      r_bsize   <= w_bsize_nxt;
      r_offset  <= w_offset_nxt;
      r_beat    <= w_beat_nxt;
      r_blen    <= w_blen_nxt;
      r_adr     <= w_adr_nxt;
      r_cyc     <= w_cyc_nxt;
      r_cti     <= w_cti_nxt;
      r_fifo_d  <= w_fifo_d_nxt;
      r_fifo_wr <= w_fifo_wr_nxt;
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
    end
  end

  assign wbm_adr_o = r_adr;
  assign wbm_dat_o = '0;
  assign wbm_sel_o = {(WB_DW/8){r_cyc}};
  assign wbm_we_o  = 1'b0;
  assign wbm_cyc_o = r_cyc;
  assign wbm_stb_o = r_cyc;
  assign wbm_cti_o = r_cti;
  assign wbm_bte_o = 2'b00;
  assign fifo_d    = r_fifo_d;
  assign fifo_wr   = r_fifo_wr;
  assign busy      = (r_state != StIdle);
  assign done      = r_done;
  assign err       = r_err;

endmodule
